// File: rtl/ultrasonic_scheduler.sv
// Round-robin scheduler that shares one HC-SR04 measurement engine among up to
// four ultrasonic sensors. It steers the trigger and echo, spaces the pings apart,
// resets the engine when an echo never arrives, and keeps one result per sensor.
//
// Ports:
//   clk_i, rst_i       clock, asynchronous active-high reset
//   en_i               run the scheduler; dropping it aborts the ping in flight
//   chan_en_i          per-sensor enable mask
//   thresh_i           obstacle threshold in raw echo cycles
//   echo_in_i          sensor echo pins; trig_out_o: sensor trigger pins
//   eng_*              handshake with the engine (measure/ready/trig/echo/rst/dist)
//   rd_sel_i           result read select; rd_dist_o: stored count (combinational)
//   valid_o, tmo_o, obstacle_o   per-sensor result flags
//   done_o, done_id_o  one-cycle pulse per finished attempt, and its sensor
module ultrasonic_scheduler #(
    parameter int unsigned N_SENS      = 4,
    parameter int unsigned TIMEOUT_CYC = 2_500_000,
    parameter int unsigned GAP_CYC     = 500_000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic [N_SENS-1:0] chan_en_i,
    input  logic [21:0]       thresh_i,
    input  logic [N_SENS-1:0] echo_in_i,
    output logic [N_SENS-1:0] trig_out_o,
    output logic              eng_measure_o,
    input  logic              eng_ready_i,
    input  logic              eng_trig_i,
    output logic              eng_echo_o,
    output logic              eng_rst_o,
    input  logic [21:0]       eng_dist_i,
    input  logic [1:0]        rd_sel_i,
    output logic [21:0]       rd_dist_o,
    output logic [N_SENS-1:0] valid_o,
    output logic [N_SENS-1:0] tmo_o,
    output logic [N_SENS-1:0] obstacle_o,
    output logic              done_o,
    output logic [1:0]        done_id_o
);

    localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int unsigned GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [TW-1:0] TmoLast = TW'(TIMEOUT_CYC - 1);
    localparam logic [GW-1:0] GapLast = GW'(GAP_CYC - 1);

    typedef enum logic [1:0] {StIdle, StStart, StBusy, StGap} state_e;

    state_e            state_q;
    logic [1:0]        ch_q;
    logic [TW-1:0]     tmo_cnt_q;
    logic [GW-1:0]     gap_cnt_q;
    logic              seen_q;
    logic              measure_q;
    logic              abort_q;
    logic              done_q;
    logic [1:0]        done_id_q;
    logic [N_SENS-1:0] valid_q;
    logic [N_SENS-1:0] tmo_q;
    logic [N_SENS-1:0] obst_q;
    logic [21:0]       result_q [N_SENS];

    // Channel search: distance of sensor i ahead of ch_q, wrapping. first_ch may
    // pick ch_q itself; next_ch treats ch_q as a full lap away so it only wins
    // when it is the sole enabled sensor.
    logic [1:0]  first_ch, next_ch;
    int unsigned ch_int, dist_v, dist_n, best_first, best_next;

    always_comb begin
        first_ch   = ch_q;
        next_ch    = ch_q;
        ch_int     = 32'(ch_q);
        dist_v     = 0;
        dist_n     = 0;
        best_first = N_SENS;
        best_next  = N_SENS + 1;
        for (int unsigned i = 0; i < N_SENS; i++) begin
            dist_v = (i >= ch_int) ? (i - ch_int) : (i + N_SENS - ch_int);
            dist_n = (dist_v == 0) ? N_SENS : dist_v;
            if (chan_en_i[i] && dist_v < best_first) begin
                best_first = dist_v;
                first_ch   = 2'(i);
            end
            if (chan_en_i[i] && dist_n < best_next) begin
                best_next = dist_n;
                next_ch   = 2'(i);
            end
        end
    end

    // Routing and result read-out.
    always_comb begin
        trig_out_o = '0;
        eng_echo_o = 1'b0;
        rd_dist_o  = '0;
        for (int unsigned i = 0; i < N_SENS; i++) begin
            if (ch_q == 2'(i)) begin
                if (state_q == StStart || state_q == StBusy) trig_out_o[i] = eng_trig_i;
                if (state_q == StBusy) eng_echo_o = echo_in_i[i];
            end
            if (rd_sel_i == 2'(i)) rd_dist_o = result_q[i];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            ch_q      <= '0;
            tmo_cnt_q <= '0;
            gap_cnt_q <= '0;
            seen_q    <= 1'b0;
            measure_q <= 1'b0;
            abort_q   <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= '0;
            valid_q   <= '0;
            tmo_q     <= '0;
            obst_q    <= '0;
            for (int unsigned i = 0; i < N_SENS; i++) result_q[i] <= '0;
        end else begin
            measure_q <= 1'b0;
            abort_q   <= 1'b0;
            done_q    <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (en_i && chan_en_i != '0) begin
                        ch_q    <= first_ch;
                        state_q <= StStart;
                    end
                end
                StStart: begin
                    if (!en_i) begin
                        abort_q <= 1'b1;
                        state_q <= StIdle;
                    end else if (eng_ready_i) begin
                        measure_q <= 1'b1;
                        tmo_cnt_q <= '0;
                        seen_q    <= 1'b0;
                        state_q   <= StBusy;
                    end
                end
                StBusy: begin
                    if (!en_i) begin
                        abort_q <= 1'b1;
                        state_q <= StIdle;
                    end else if (seen_q && eng_ready_i) begin
                        // Completion is checked before timeout so it wins a tie.
                        for (int unsigned i = 0; i < N_SENS; i++) begin
                            if (ch_q == 2'(i)) begin
                                result_q[i] <= eng_dist_i;
                                valid_q[i]  <= 1'b1;
                                tmo_q[i]    <= 1'b0;
                                obst_q[i]   <= (eng_dist_i < thresh_i);
                            end
                        end
                        done_q    <= 1'b1;
                        done_id_q <= ch_q;
                        gap_cnt_q <= '0;
                        state_q   <= StGap;
                    end else if (tmo_cnt_q == TmoLast) begin
                        for (int unsigned i = 0; i < N_SENS; i++) begin
                            if (ch_q == 2'(i)) begin
                                valid_q[i] <= 1'b0;
                                tmo_q[i]   <= 1'b1;
                                obst_q[i]  <= 1'b0;
                            end
                        end
                        abort_q   <= 1'b1;
                        done_q    <= 1'b1;
                        done_id_q <= ch_q;
                        gap_cnt_q <= '0;
                        state_q   <= StGap;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
                        if (!eng_ready_i) seen_q <= 1'b1;
                    end
                end
                StGap: begin
                    if (!en_i) begin
                        state_q <= StIdle;
                    end else if (gap_cnt_q == GapLast) begin
                        if (chan_en_i == '0) begin
                            state_q <= StIdle;
                        end else begin
                            ch_q    <= next_ch;
                            state_q <= StStart;
                        end
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign eng_measure_o = measure_q;
    assign eng_rst_o     = rst_i | abort_q;
    assign valid_o       = valid_q;
    assign tmo_o         = tmo_q;
    assign obstacle_o    = obst_q;
    assign done_o        = done_q;
    assign done_id_o     = done_id_q;

endmodule

// File: tb/tb_ultrasonic_scheduler.sv
// Directed bench for ultrasonic_scheduler with a behavioural HC-SR04 engine and
// per-sensor echo responders.
module tb_ultrasonic_scheduler;

    localparam int unsigned NS     = 4;
    localparam int unsigned TMO    = 200;
    localparam int unsigned GAP    = 20;
    localparam int unsigned TEN_US = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en;
    logic [3:0]  chan_en;
    logic [21:0] thresh;
    logic [3:0]  echo_in;
    logic [3:0]  trig_out;
    logic        eng_measure, eng_ready, eng_trig, eng_echo, eng_rst;
    logic [21:0] eng_dist, rd_dist;
    logic [1:0]  rd_sel, done_id;
    logic [3:0]  valid, tmo, obstacle;
    logic        done;

    int errors = 0;
    int checks = 0;
    int wait_n = 0;

    always #5 clk = ~clk;

    ultrasonic_scheduler #(
        .N_SENS      (NS),
        .TIMEOUT_CYC (TMO),
        .GAP_CYC     (GAP)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .en_i          (en),
        .chan_en_i     (chan_en),
        .thresh_i      (thresh),
        .echo_in_i     (echo_in),
        .trig_out_o    (trig_out),
        .eng_measure_o (eng_measure),
        .eng_ready_i   (eng_ready),
        .eng_trig_i    (eng_trig),
        .eng_echo_o    (eng_echo),
        .eng_rst_o     (eng_rst),
        .eng_dist_i    (eng_dist),
        .rd_sel_i      (rd_sel),
        .rd_dist_o     (rd_dist),
        .valid_o       (valid),
        .tmo_o         (tmo),
        .obstacle_o    (obstacle),
        .done_o        (done),
        .done_id_o     (done_id)
    );

    // Engine model: TEN_US-cycle trigger, then counts cycles of high echo.
    typedef enum logic [1:0] {EIdle, ETrig, EWait, EEcho} eng_st_e;
    eng_st_e     est;
    int          tcnt;
    logic [21:0] ecnt;

    always @(posedge clk or posedge eng_rst) begin
        if (eng_rst) begin
            est <= EIdle; eng_ready <= 1'b1; eng_trig <= 1'b0;
            tcnt <= 0; ecnt <= '0; eng_dist <= '0;
        end else begin
            case (est)
                EIdle: if (eng_measure) begin
                    eng_ready <= 1'b0; eng_trig <= 1'b1; tcnt <= 0; est <= ETrig;
                end
                ETrig: if (tcnt == int'(TEN_US) - 1) begin
                    eng_trig <= 1'b0; est <= EWait;
                end else tcnt <= tcnt + 1;
                EWait: if (eng_echo) begin ecnt <= 22'd1; est <= EEcho; end
                EEcho: if (eng_echo) ecnt <= ecnt + 22'd1;
                       else begin eng_dist <= ecnt; eng_ready <= 1'b1; est <= EIdle; end
                default: est <= EIdle;
            endcase
        end
    end

    // Sensors: echo goes high 5 cycles after trigger falls, for len[i] cycles.
    int   len [4];
    int   sc  [4];
    logic [3:0] trig_d;

    always @(posedge clk) begin
        if (rst) begin
            trig_d <= '0;
            for (int i = 0; i < 4; i++) sc[i] <= 0;
        end else begin
            trig_d <= trig_out;
            for (int i = 0; i < 4; i++) begin
                if (trig_d[i] && !trig_out[i] && len[i] != 0) sc[i] <= 5 + len[i];
                else if (sc[i] != 0) sc[i] <= sc[i] - 1;
            end
        end
    end

    always_comb begin
        echo_in = '0;
        for (int i = 0; i < 4; i++) echo_in[i] = (sc[i] != 0) && (sc[i] <= len[i]);
    end

    // Event monitors.
    int   rst_pulses = 0, done_cnt = 0, meas_cnt = 0, run0 = 0, last_w0 = 0;
    logic trig2_seen = 1'b0;

    always @(negedge clk) begin
        if (!rst && eng_rst === 1'b1) rst_pulses++;
        if (!rst && done === 1'b1) done_cnt++;
        if (eng_measure === 1'b1) meas_cnt++;
        if (trig_out[2] === 1'b1) trig2_seen = 1'b1;
        if (trig_out[0] === 1'b1) run0++;
        else begin
            if (run0 != 0) last_w0 = run0;
            run0 = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // which: 0 = done, 1 = eng_measure, 2 = eng_echo. wait_n = cycles waited.
    task automatic wait_sig(input string tag, input int which, input int budget);
        int   n;
        logic hit;
        n   = 0;
        hit = 1'b0;
        while (!hit && n < budget) begin
            @(negedge clk);
            n++;
            case (which)
                0:       hit = (done === 1'b1);
                1:       hit = (eng_measure === 1'b1);
                default: hit = (eng_echo === 1'b1);
            endcase
        end
        wait_n = n;
        checks++;
        assert (hit) else begin
            errors++;
            $error("FAIL %s: event not seen within %0d cycles", tag, budget);
        end
    endtask

    task automatic read_dist(input logic [1:0] sel, input string tag, input int exp);
        rd_sel = sel;
        #1;
        chk(tag, 32'(rd_dist), exp);
    endtask

    int rr_exp [6];
    int p0, d0, m0;

    initial begin
        en = 1'b0; chan_en = '0; thresh = '0; rd_sel = '0;
        for (int i = 0; i < 4; i++) len[i] = 0;
        rr_exp = '{0, 1, 3, 0, 1, 3};
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state.
        chk("rst_valid", 32'(valid), 0);
        chk("rst_tmo", 32'(tmo), 0);
        chk("rst_obstacle", 32'(obstacle), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_measure", 32'(eng_measure), 0);
        chk("rst_eng_rst", 32'(eng_rst), 1);
        chk("rst_trig", 32'(trig_out), 0);
        chk("rst_rd_dist", 32'(rd_dist), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_eng_rst_low", 32'(eng_rst), 0);

        // Single sensor: 100-cycle echo, 20-cycle trigger, ping spacing.
        len[0] = 100; chan_en = 4'b0001; en = 1'b1;
        wait_sig("ss_done", 0, 1000);
        chk("ss_done_id", 32'(done_id), 0);
        chk("ss_trig_width", 32'(last_w0), TEN_US);
        chk("ss_valid", 32'(valid), 4'b0001);
        chk("ss_tmo", 32'(tmo), 0);
        read_dist(2'd0, "ss_dist", 100);
        // GAP cycles after done, then one START cycle before measure is seen.
        wait_sig("ss_gap", 1, 100);
        chk("ss_gap_cycles", 32'(wait_n), GAP + 1);
        wait_sig("ss_done2", 0, 1000);
        chk("ss_done2_id", 32'(done_id), 0);
        chan_en = '0;
        repeat (GAP + 10) @(negedge clk);

        // Round-robin over sensors 0, 1, 3.
        trig2_seen = 1'b0;
        len[0] = 50; len[1] = 50; len[3] = 50; chan_en = 4'b1011;
        for (int k = 0; k < 6; k++) begin
            wait_sig("rr_done", 0, 1000);
            chk("rr_done_id", 32'(done_id), rr_exp[k]);
        end
        chan_en = '0;
        chk("rr_trig2", 32'(trig2_seen), 0);
        chk("rr_valid", 32'(valid), 4'b1011);
        read_dist(2'd1, "rr_dist1", 50);
        read_dist(2'd3, "rr_dist3", 50);
        repeat (GAP + 10) @(negedge clk);

        // Timeout on sensor 1, then a normal retry.
        len[1] = 0; chan_en = 4'b0010; p0 = rst_pulses; d0 = done_cnt;
        wait_sig("to_meas", 1, 50);
        wait_sig("to_done", 0, 400);
        chk("to_cycles", 32'(wait_n), TMO);
        chk("to_done_id", 32'(done_id), 1);
        repeat (3) @(negedge clk);
        chk("to_rst_pulses", 32'(rst_pulses - p0), 1);
        chk("to_done_cnt", 32'(done_cnt - d0), 1);
        chk("to_tmo", 32'(tmo), 4'b0010);
        chk("to_valid", 32'(valid), 4'b1001);
        read_dist(2'd1, "to_dist_kept", 50);
        len[1] = 70;
        wait_sig("to_retry", 0, 600);
        chk("to_retry_id", 32'(done_id), 1);
        chk("to_retry_valid", 32'(valid), 4'b1011);
        chk("to_retry_tmo", 32'(tmo), 0);
        read_dist(2'd1, "to_retry_dist", 70);
        chan_en = '0;
        repeat (GAP + 10) @(negedge clk);

        // Obstacle flag against threshold 80.
        thresh = 22'd80; len[0] = 60; chan_en = 4'b0001;
        wait_sig("ob_done1", 0, 600);
        chk("ob_id1", 32'(done_id), 0);
        chk("ob_near", 32'(obstacle), 4'b0001);
        read_dist(2'd0, "ob_dist1", 60);
        len[0] = 120;
        wait_sig("ob_done2", 0, 600);
        chk("ob_far", 32'(obstacle), 4'b0000);
        read_dist(2'd0, "ob_dist2", 120);
        thresh = 22'd200;
        repeat (3) @(negedge clk);
        chk("ob_no_recompute", 32'(obstacle), 4'b0000);
        chan_en = '0;
        repeat (GAP + 10) @(negedge clk);

        // Abort mid-echo on sensor 2, then restart at sensor 2.
        len[2] = 100; len[3] = 40; chan_en = 4'b1100;
        p0 = rst_pulses; d0 = done_cnt;
        wait_sig("ab_echo", 2, 300);
        repeat (10) @(negedge clk);
        en = 1'b0;
        repeat (3) @(negedge clk);
        chk("ab_rst_pulse", 32'(rst_pulses - p0), 1);
        chk("ab_no_done", 32'(done_cnt - d0), 0);
        chk("ab_valid", 32'(valid), 4'b1011);
        chk("ab_trig", 32'(trig_out), 0);
        read_dist(2'd2, "ab_dist2", 0);
        m0 = meas_cnt;
        repeat (120) @(negedge clk);
        chk("ab_idle", 32'(meas_cnt - m0), 0);
        en = 1'b1;
        wait_sig("ab_restart", 0, 600);
        chk("ab_restart_id", 32'(done_id), 2);
        read_dist(2'd2, "ab_restart_dist", 100);

        // Reset while sensor 3 is in BUSY.
        wait_sig("rb_meas", 1, 100);
        repeat (5) @(negedge clk);
        chk("rb_trig_before", 32'(trig_out), 4'b1000);
        rst = 1'b1;
        #1;
        chk("rb_trig", 32'(trig_out), 0);
        chk("rb_valid", 32'(valid), 0);
        chk("rb_tmo", 32'(tmo), 0);
        chk("rb_obstacle", 32'(obstacle), 0);
        chk("rb_done", 32'(done), 0);
        chk("rb_measure", 32'(eng_measure), 0);
        chk("rb_eng_rst", 32'(eng_rst), 1);
        chk("rb_echo", 32'(eng_echo), 0);
        chk("rb_rd_dist", 32'(rd_dist), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
